// File: rtl/logic_alu_pipe_if.sv
// logic_alu_pipe_if: operand/op request and registered result bundle for logic_alu_pipe
interface logic_alu_pipe_if #(parameter int WIDTH = 8);
  logic valid;
  logic [2:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic acc_en;
  logic clr;
  logic out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_not;
  logic zero;
  logic [WIDTH-1:0] acc;
  logic [15:0] count;
  modport master (
    output valid, op, a, b, acc_en, clr,
    input out_valid, result, y_and, y_or, y_not, zero, acc, count
  );
  modport slave (
    input valid, op, a, b, acc_en, clr,
    output out_valid, result, y_and, y_or, y_not, zero, acc, count
  );
endinterface

// File: rtl/logic_alu_pipe.sv
// logic_alu_pipe: pipelined WIDTH-bit logic unit with accumulator chaining and valid-qualified outputs
module logic_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  logic_alu_pipe_if.slave bus
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] ops [8];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] p_zero;
  logic [WIDTH-1:0] p_res [STAGES];
  logic [WIDTH-1:0] p_and [STAGES];
  logic [WIDTH-1:0] p_or [STAGES];
  logic [WIDTH-1:0] p_not [STAGES];
  logic [15:0] count;
  assign op_a = bus.acc_en ? acc : bus.a;
  // One result per op code; the op field simply indexes this table
  always_comb begin
    ops[0] = op_a & bus.b;
    ops[1] = op_a | bus.b;
    ops[2] = ~op_a;
    ops[3] = op_a ^ bus.b;
    ops[4] = ~(op_a & bus.b);
    ops[5] = ~(op_a | bus.b);
    ops[6] = ~(op_a ^ bus.b);
    ops[7] = bus.b;
  end
  assign res = ops[bus.op];
  // Valid bits shift every cycle; each stage's data loads only behind a valid so outputs hold in bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      p_zero <= '0;
      for (int s = 0; s < STAGES; s++) begin
        p_res[s] <= '0;
        p_and[s] <= '0;
        p_or[s] <= '0;
        p_not[s] <= '0;
      end
    end else begin
      v[0] <= bus.valid;
      if (bus.valid) begin
        p_res[0] <= res;
        p_and[0] <= op_a & bus.b;
        p_or[0] <= op_a | bus.b;
        p_not[0] <= ~op_a;
        p_zero[0] <= res == '0;
      end
      for (int s = 1; s < STAGES; s++) begin
        v[s] <= v[s-1];
        if (v[s-1]) begin
          p_res[s] <= p_res[s-1];
          p_and[s] <= p_and[s-1];
          p_or[s] <= p_or[s-1];
          p_not[s] <= p_not[s-1];
          p_zero[s] <= p_zero[s-1];
        end
      end
    end
  end
  // Accumulator updates at stage 1 so the next op can chain; clear wins but the clearing op still used the old value
  always_ff @(posedge clk) begin
    if (rst || bus.clr) acc <= '0;
    else if (bus.valid && bus.acc_en) acc <= res;
  end
  // Saturating count of output valid pulses
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (v[STAGES-1] && count != 16'hFFFF) count <= count + 16'd1;
  end
  assign bus.out_valid = v[STAGES-1];
  assign bus.result = p_res[STAGES-1];
  assign bus.y_and = p_and[STAGES-1];
  assign bus.y_or = p_or[STAGES-1];
  assign bus.y_not = p_not[STAGES-1];
  assign bus.zero = p_zero[STAGES-1];
  assign bus.acc = acc;
  assign bus.count = count;
endmodule

// File: tb/tb_logic_alu_pipe.sv
// tb_logic_alu_pipe: directed and randomized checks of logic_alu_pipe against a queue-based reference model
module tb_logic_alu_pipe;
  localparam int W = 8;
  localparam int S = 2;
  typedef struct {
    int due;
    logic [W-1:0] r;
    logic [W-1:0] an;
    logic [W-1:0] o;
    logic [W-1:0] n;
    logic z;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic_alu_pipe_if #(.WIDTH(W)) bus ();
  logic_alu_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  ent_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] acc_m = '0, m_r = '0, m_an = '0, m_o = '0, m_n = '0;
  logic m_z = 1'b0, m_v = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [W-1:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h0F, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hCC};
  logic [W-1:0] chain_b [3] = '{8'h01, 8'h02, 8'h04};
  logic [W-1:0] chain_acc [3] = '{8'h01, 8'h03, 8'h07};

  function automatic logic [W-1:0] ref_op(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~x;
      3'd3: return x ^ y;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ae, logic cl);
    bus.valid = v;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.acc_en = ae;
    bus.clr = cl;
  endtask

  task automatic step();
    ent_t e;
    logic [W-1:0] opa, r;
    if (rst) begin
      q.delete();
      acc_m = '0;
      {m_r, m_an, m_o, m_n} = '0;
      m_z = 1'b0;
      m_v = 1'b0;
      m_cnt = '0;
    end else begin
      opa = bus.acc_en ? acc_m : bus.a;
      r = ref_op(bus.op, opa, bus.b);
      if (bus.valid) q.push_back('{cyc + S, r, opa & bus.b, opa | bus.b, ~opa, r == '0});
      if (bus.clr) acc_m = '0;
      else if (bus.valid && bus.acc_en) acc_m = r;
      if (m_v && m_cnt != 16'hFFFF) m_cnt++;
      m_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        e = q.pop_front();
        {m_r, m_an, m_o, m_n, m_z} = {e.r, e.an, e.o, e.n, e.z};
        m_v = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, m_v);
    check("result", bus.result, m_r);
    check("and", bus.y_and, m_an);
    check("or", bus.y_or, m_o);
    check("not", bus.y_not, m_n);
    check("zero", bus.zero, m_z);
    check("acc", bus.acc, acc_m);
    check("count", bus.count, m_cnt);
  endtask

  initial begin
    drive(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_and", bus.y_and, 0);
    check("rst_or", bus.y_or, 0);
    check("rst_not", bus.y_not, 0);
    check("rst_acc", bus.acc, 0);
    check("rst_count", bus.count, 0);
    check("rst_zero", bus.zero, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
      step();
      if (i > 0) check("sweep_result", bus.result, sweep_exp[i-1]);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("sweep_last", bus.result, sweep_exp[7]);
    check("sweep_and", bus.y_and, 8'hC0);
    check("sweep_or", bus.y_or, 8'hFC);
    check("sweep_not", bus.y_not, 8'h0F);
    step();
    check("sweep_count", bus.count, 8);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 8'h00, chain_b[i], 1'b1, 1'b0);
      step();
      check("chain_acc", bus.acc, chain_acc[i]);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("chain_res", bus.result, 8'h07);
    drive(1'b1, 3'd3, 8'h00, 8'hFF, 1'b1, 1'b1);
    step();
    check("clr_acc", bus.acc, 0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("clr_res", bus.result, 8'hF8);
    for (int i = 0; i < 5; i++) begin
      drive(i != 1 && i < 3, 3'd0, 8'h0F, 8'hF0, 1'b0, 1'b0);
      step();
    end
    check("bubble_zero", bus.zero, 1);
    check("bubble_res", bus.result, 0);
    drive(1'b1, 3'd1, 8'h12, 8'h34, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("inflight_valid", bus.out_valid, 0);
      check("inflight_count", bus.count, 0);
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), $urandom_range(0, 7) == 0);
      rst = $urandom_range(0, 49) == 0;
      step();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_alu_pipe.md
Name: logic_alu_pipe

Overview:
- Parametrised, pipelined successor to the 2-input gate block: WIDTH-bit bitwise logic unit with 8 selectable ops, an internal accumulator for chained operations, and valid-qualified outputs.
- Keeps the oAnd/oOr/oNot outputs, now registered and WIDTH-bit wide.
- Adds a result mux, zero flag and a result counter.
- Sits between operand registers and display/LED logic in lab datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32).
- STAGES, 2, pipeline latency in cycles from input sample to output (1..4).

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  operands and op valid this cycle.
- iOp  input  3  op select: 000 AND, 001 OR, 010 NOT A, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS B.
- iA  input  WIDTH  operand A.
- iB  input  WIDTH  operand B.
- iAccEn  input  1  1: use accumulator as operand A and write the result back to it.
- iClr  input  1  clear accumulator.
- oValid  output  1  result valid, STAGES cycles after iValid.
- oResult  output  WIDTH  selected op result.
- oAnd  output  WIDTH  A&B.
- oOr  output  WIDTH  A|B.
- oNot  output  WIDTH  ~A.
- oZero  output  1  oResult==0.
- oAcc  output  WIDTH  accumulator register, unpipelined.
- oCount  output  16  number of oValid pulses since reset, saturating.

Behaviour:
- Reset (iRst=1 at a rising edge): all pipeline registers, oValid, all data outputs, oZero, accumulator and oCount go to 0 on that edge. iValid, iClr and iAccEn are ignored that cycle.
- Operand select: opA = iAccEn ? acc : iA; opB = iB always. oAnd/oOr/oNot use opA, not iA.
- Stage 1 (combinational into first register) computes opA&opB, opA|opB, ~opA, the iOp result, and zero = (result==0).
- Stages 2..STAGES form a pure delay line.
- Each stage's data registers load only when the incoming valid bit is 1. Otherwise they hold, so outputs keep their last valid values while oValid=0.
- Valid bits shift every cycle unconditionally. Latency is exactly STAGES cycles; throughput is 1 op/cycle with no stalls.
- Accumulator priority per cycle:
  - iClr=1: acc<=0. Wins over writeback; the op in that cycle still uses the old acc and its result still enters the pipeline.
  - else iValid&iAccEn: acc<=result.
  - else hold.
- Back-to-back chaining is supported because acc updates at stage 1, so the next cycle's op sees the new value.
- oAcc reflects the acc register directly, one cycle after the update edge, independent of STAGES.
- oCount increments on every cycle with oValid=1 and sticks at 16'hFFFF.
- Reset mid-operation: in-flight valid bits are cleared. No oValid ever appears for ops accepted before the reset edge.
- iOp is used only when iValid=1. Undefined codes do not exist, since all 8 are defined.

Test Plan (WIDTH=8, STAGES=2):
- Reset: hold iRst=1 two cycles with iValid=1, iA=FF, iB=FF -> oValid=0, oResult=oAnd=oOr=oNot=00, oAcc=00, oCount=0, oZero=0.
- Op sweep: iA=F0, iB=CC, iOp=0..7 on 8 consecutive valid cycles.
  - Required oResult, starting 2 cycles after the first op: C0, FC, 0F, 3C, 3F, 03, C3, CC.
  - oValid high 8 cycles; oAnd=C0, oOr=FC, oNot=0F throughout; oCount=8.
- Accumulator chain: iClr pulse, then iAccEn=1, iOp=OR, iB=01, 02, 04 back-to-back -> oAcc=01, 03, 07 on successive cycles; oResult=01, 03, 07 two cycles after each op.
- Clear vs writeback: acc=07; iValid=1, iAccEn=1, iClr=1, iOp=XOR, iB=FF -> oResult=F8 two cycles later, oAcc=00 next cycle.
- Bubble/zero: iValid pattern 1,0,1 with iA=0F, iB=F0, AND -> oValid 1,0,1 delayed 2; oResult=00 and oZero=1 held through the bubble.
- Reset in flight: valid op at cycle n, iRst=1 at cycle n+1 -> oValid stays 0 for cycles n+1..n+4; oCount stays 0.
